// File: rtl/spi_frame_master.sv
// SPI mode-0 master that shifts one NBYTES-byte frame per SSEL low period,
// full duplex, MSB first, reading transmit data from a byte-indexed buffer.
module spi_frame_master #(
  parameter int NBYTES   = 20,
  parameter int HALF     = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic [4:0] byte_idx,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic [4:0] rx_idx,
  output logic       rx_valid,
  output logic       done,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int TAIL_LEN = HALF + CS_HOLD;
  localparam int DIV_M1   = (TAIL_LEN > CS_SETUP) ? TAIL_LEN : CS_SETUP;
  localparam int DIV_MAX  = (DIV_M1 > CS_IDLE) ? DIV_M1 : CS_IDLE;
  localparam int DW       = $clog2(DIV_MAX + 1);
  localparam logic [4:0] LAST_BYTE = 5'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_GAP
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next;
  logic [2:0]    bit_reg, bit_next;
  logic [4:0]    byte_idx_reg, byte_idx_next;
  logic [6:0]    shift_reg, shift_next;
  logic [6:0]    rx_shift_reg, rx_shift_next;
  logic [7:0]    rx_byte_reg, rx_byte_next;
  logic [4:0]    rx_idx_reg, rx_idx_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic          sck_reg, sck_next;
  logic          ssel_reg, ssel_next;
  logic          mosi_reg, mosi_next;
  logic          phase_end;

  // Last clk cycle of the current timed phase.
  always_comb begin
    phase_end = 1'b0;
    case (state_reg)
      ST_SETUP: phase_end = (div_reg == DW'(CS_SETUP - 1));
      ST_LOW:   phase_end = (div_reg == DW'(HALF - 1));
      ST_HIGH:  phase_end = (div_reg == DW'(HALF - 1));
      ST_TAIL:  phase_end = (div_reg == DW'(TAIL_LEN - 1));
      ST_GAP:   phase_end = (div_reg == DW'(CS_IDLE - 1));
      default:  phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      rx_shift_reg <= '0;
      rx_byte_reg  <= '0;
      rx_idx_reg   <= '0;
      rx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      sck_reg      <= 1'b0;
      ssel_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_byte_reg  <= rx_byte_next;
      rx_idx_reg   <= rx_idx_next;
      rx_valid_reg <= rx_valid_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
      sck_reg      <= sck_next;
      ssel_reg     <= ssel_next;
      mosi_reg     <= mosi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg + DW'(1);
    bit_next   = bit_reg;
    case (state_reg)
      ST_IDLE: begin
        bit_next = '0;
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: if (phase_end) state_next = ST_LOW;
      ST_LOW:   if (phase_end) state_next = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7 && byte_idx_reg == LAST_BYTE) state_next = ST_TAIL;
          else                                              state_next = ST_LOW;
        end
      end
      ST_TAIL: if (phase_end) state_next = ST_GAP;
      ST_GAP:  if (phase_end) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Every phase times itself from zero.
    if (state_next != state_reg || state_reg == ST_IDLE) div_next = '0;
  end

  always_comb begin
    sck_next      = sck_reg;
    ssel_next     = ssel_reg;
    mosi_next     = mosi_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rx_valid_next = 1'b0;
    rx_byte_next  = rx_byte_reg;
    rx_idx_next   = rx_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    rx_shift_next = rx_shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          ssel_next     = 1'b0;
          busy_next     = 1'b1;
          byte_idx_next = '0;
        end
      end
      ST_LOW: begin
        // The caller gets one cycle after byte_idx moves to present tx_byte.
        if (bit_reg == 3'd0 && div_reg == '0) begin
          shift_next = tx_byte[6:0];
          mosi_next  = tx_byte[7];
        end
        if (phase_end) sck_next = 1'b1;
      end
      ST_HIGH: begin
        if (phase_end) begin
          sck_next      = 1'b0;
          rx_shift_next = {rx_shift_reg[5:0], MISO};
          if (bit_reg != 3'd7) begin
            mosi_next  = shift_reg[6];
            shift_next = {shift_reg[5:0], 1'b0};
          end else begin
            rx_byte_next  = {rx_shift_reg, MISO};
            rx_idx_next   = byte_idx_reg;
            rx_valid_next = 1'b1;
            if (byte_idx_reg != LAST_BYTE) byte_idx_next = byte_idx_reg + 5'd1;
          end
        end
      end
      ST_TAIL: begin
        if (phase_end) begin
          ssel_next = 1'b1;
          done_next = 1'b1;
          mosi_next = 1'b0;
        end
      end
      ST_GAP: if (phase_end) busy_next = 1'b0;
      default: ;
    endcase
  end

  assign busy     = busy_reg;
  assign byte_idx = byte_idx_reg;
  assign rx_byte  = rx_byte_reg;
  assign rx_idx   = rx_idx_reg;
  assign rx_valid = rx_valid_reg;
  assign done     = done_reg;
  assign SCK      = sck_reg;
  assign SSEL     = ssel_reg;
  assign MOSI     = mosi_reg;

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomized scoreboard bench for spi_frame_master: loopback and slave-model
// frames, frame timing, ignored starts, back-to-back frames, mid-frame reset.
`timescale 1ns/1ps
module tb_spi_frame_master;
  localparam int NBYTES    = 20;
  localparam int HALF      = 4;
  localparam int CS_SETUP  = 4;
  localparam int CS_HOLD   = 4;
  localparam int CS_IDLE   = 8;
  localparam int FRAME_LEN = CS_SETUP + NBYTES * 16 * HALF + HALF + CS_HOLD;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       busy, rx_valid, done, SCK, SSEL, MOSI, MISO;
  logic [4:0] byte_idx, rx_idx;
  logic [7:0] tx_byte, rx_byte;

  always #5 clk = ~clk;

  logic [7:0]  tx_mem   [NBYTES];
  logic [7:0]  resp_mem [NBYTES];
  bit          slave_mode = 1'b0;
  logic [12:0] exp_q[$];
  int checks = 0, errors = 0;
  int frame_starts = 0, dones = 0, exp_frames = 0, exp_dones = 0;
  bit b2b = 1'b0;

  spi_frame_master #(
    .NBYTES(NBYTES), .HALF(HALF), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .byte_idx(byte_idx),
    .tx_byte(tx_byte), .rx_byte(rx_byte), .rx_idx(rx_idx), .rx_valid(rx_valid),
    .done(done), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
  );

  // Frame buffer read is combinational.
  assign tx_byte = tx_mem[byte_idx];

  // Slave model: shifts its response out MSB first, advancing after each SCK fall.
  int   fall_cnt = 0;
  logic slv_sck_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || SSEL)              fall_cnt <= 0;
    else if (slv_sck_prev && !SCK)   fall_cnt <= fall_cnt + 1;
    slv_sck_prev <= SCK;
  end

  always_comb begin
    MISO = MOSI;
    if (slave_mode) begin
      if (fall_cnt < NBYTES * 8) MISO = resp_mem[fall_cnt / 8][7 - fall_cnt % 8];
      else                       MISO = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes on rx_valid and checks frame timing.
  initial begin : monitor
    logic [12:0] e;
    logic ssel_prev, sck_prev, mosi_prev;
    int   mosi_cnt, low_len, high_len, rises, gap_cnt, rx_cnt;
    bit   gap_on;
    ssel_prev = 1'b1; sck_prev = 1'b0; mosi_prev = 1'b0;
    mosi_cnt = 0; low_len = 0; high_len = 0; rises = 0; gap_cnt = 0; rx_cnt = 0; gap_on = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ssel_prev = 1'b1; sck_prev = 1'b0; mosi_prev = MOSI;
        mosi_cnt = 0; high_len = 0; gap_on = 1'b0; rx_cnt = 0;
      end else begin
        mosi_cnt = (MOSI === mosi_prev) ? mosi_cnt + 1 : 1;
        if (rx_valid) begin
          rx_cnt++;
          if (exp_q.size() == 0) begin
            check("rx_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rx_idx", rx_idx, e[12:8]);
            check("rx_byte", rx_byte, e[7:0]);
          end
        end
        if (ssel_prev && !SSEL) begin
          frame_starts++;
          if (b2b && high_len > 0) check("b2b_ssel_high", high_len, CS_IDLE + 1);
          low_len = 0; rises = 0; rx_cnt = 0;
        end
        if (!ssel_prev && SSEL) begin
          high_len = 0;
          check("done_at_ssel_rise", done, 1);
        end
        if (!SSEL) low_len++;
        else       high_len++;
        if (SCK && !sck_prev) begin
          check("sck_rise_ssel_low", SSEL, 0);
          if (rises < NBYTES * 8) begin
            check("mosi_bit", MOSI, tx_mem[rises / 8][7 - rises % 8]);
            check("byte_idx", byte_idx, rises / 8);
          end
          check("mosi_setup", (mosi_cnt - 1 >= HALF - 1), 1);
          rises++;
        end
        if (done) begin
          check("done_ssel_high", SSEL, 1);
          check("done_first_high", ssel_prev, 0);
          check("frame_len", low_len, FRAME_LEN);
          check("sck_rises", rises, NBYTES * 8);
          check("rx_per_frame", rx_cnt, NBYTES);
          dones++;
          gap_on = 1'b1; gap_cnt = 0;
        end
        if (gap_on) begin
          if (busy) gap_cnt++;
          else begin
            check("gap_len", gap_cnt, CS_IDLE);
            gap_on = 1'b0;
          end
        end
        ssel_prev = SSEL; sck_prev = SCK; mosi_prev = MOSI;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target);
    int k = 0;
    while (dones < target && k < 4000) begin step(); k++; end
    check("done_timeout", (dones >= target), 1);
  endtask

  task automatic wait_starts(input int target);
    int k = 0;
    while (frame_starts < target && k < 4000) begin step(); k++; end
    check("start_timeout", (frame_starts >= target), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin step(); k++; end
    check("busy_timeout", busy, 0);
  endtask

  task automatic load_frame(input bit mode, input bit pattern, input int copies);
    slave_mode = mode;
    for (int i = 0; i < NBYTES; i++) begin
      tx_mem[i]   = pattern ? (8'hA5 ^ 8'(i)) : 8'($urandom);
      resp_mem[i] = 8'($urandom);
    end
    for (int c = 0; c < copies; c++)
      for (int i = 0; i < NBYTES; i++)
        exp_q.push_back({5'(i), mode ? resp_mem[i] : tx_mem[i]});
  endtask

  task automatic run_frame(input bit mode, input bit pattern, input bit poke);
    int n;
    load_frame(mode, pattern, 1);
    exp_frames++; exp_dones++;
    start = 1'b1; step(); start = 1'b0;
    if (poke) begin
      n = $urandom_range(10, 1200);
      repeat (n) step();
      start = 1'b1; step(); start = 1'b0;
    end
    wait_dones(exp_dones);
    if (poke) begin
      step(); step();
      start = 1'b1; step(); start = 1'b0;
    end
    wait_idle();
    repeat (4) step();
    check("frame_count", frame_starts, exp_frames);
    check("busy_idle", busy, 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin tx_mem[i] = '0; resp_mem[i] = '0; end
    repeat (5) step();
    check("rst_sck", SCK, 0);
    check("rst_ssel", SSEL, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_rx_idx", rx_idx, 0);
    check("rst_rx_byte", rx_byte, 0);
    rst_n = 1'b1;
    repeat (3) step();

    for (int f = 0; f < 8; f++) run_frame(1'($urandom_range(0, 1)), 1'b0, f[0]);
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0);

    // start held high: three chained frames
    load_frame(1'b0, 1'b0, 3);
    exp_frames += 3; exp_dones += 3;
    start = 1'b1;
    wait_starts(exp_frames - 2);
    b2b = 1'b1;
    wait_starts(exp_frames);
    start = 1'b0;
    b2b = 1'b0;
    wait_dones(exp_dones);
    wait_idle();
    repeat (4) step();
    check("b2b_frame_count", frame_starts, exp_frames);

    // reset during byte 7, bit 3
    load_frame(1'b0, 1'b0, 1);
    exp_frames++;
    start = 1'b1; step(); start = 1'b0;
    begin
      int k = 0;
      while (byte_idx != 5'd7 && k < 2000) begin step(); k++; end
      check("reach_byte7", byte_idx, 7);
    end
    repeat (2 * HALF * 3 + 2) step();
    rst_n = 1'b0;
    step();
    check("abort_ssel", SSEL, 1);
    check("abort_sck", SCK, 0);
    check("abort_done", done, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) step();
    check("abort_no_done", dones, exp_dones);

    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);

    check("total_frames", frame_starts, exp_frames);
    check("total_dones", dones, exp_dones);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
